// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: repeat-FSM encoding and
// default timing constants for a 125 MHz clock.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_e;

   localparam int DEF_DEBOUNCE_CYCLES     = 1250000;
   localparam int DEF_REPEAT_DELAY_CYCLES = 62500000;
   localparam int DEF_REPEAT_RATE_CYCLES  = 12500000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw levels in, debounced level and event pulses out.
interface button_if #(
   parameter int N_BUTTONS = 2
);
   // BUTTONS is asynchronous; BTN_PRESS/BTN_RELEASE are single-cycle strobes
   // with no back-pressure, valid only in the cycle they are high.
   logic [N_BUTTONS-1:0] BUTTONS;
   logic [N_BUTTONS-1:0] BTN_LEVEL;
   logic [N_BUTTONS-1:0] BTN_PRESS;
   logic [N_BUTTONS-1:0] BTN_RELEASE;

   modport master (output BUTTONS, input BTN_LEVEL, input BTN_PRESS, input BTN_RELEASE);
   modport slave  (input BUTTONS, output BTN_LEVEL, output BTN_PRESS, output BTN_RELEASE);
endinterface

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, press/release
// strobes and the auto-repeat FSM.
module button_channel
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN           = 1,
   parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
   parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       button_i,
   output logic       level_o,
   output logic       press_o,
   output logic       release_o,
   output rep_state_e state_o
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMR_W = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   rep_state_e       state_q, state_d;
   logic             rise, fall, expire;

   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (sync2_q != level_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   assign rise = level_d & ~level_q;
   assign fall = ~level_d & level_q;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      expire  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_HOLD;
               tmr_d   = '0;
            end
         end
         ST_HOLD: begin
            // Without auto-repeat the channel parks here with a frozen timer.
            if (REPEAT_EN != 0) begin
               if (tmr_q == DELAY_LAST) begin
                  expire  = 1'b1;
                  state_d = ST_REPEAT;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
         end
         ST_REPEAT: begin
            if (tmr_q == RATE_LAST) begin
               expire = 1'b1;
               tmr_d  = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
         end
      endcase
      if (fall) begin
         state_d = ST_IDLE;
         tmr_d   = '0;
      end
   end

   // A falling level suppresses a repeat strobe expiring on the same edge.
   assign press_d   = rise | (expire & ~fall);
   assign release_d = fall;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         tmr_q     <= '0;
         state_q   <= ST_IDLE;
      end else begin
         sync1_q   <= button_i;
         sync2_q   <= sync1_q;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         tmr_q     <= tmr_d;
         state_q   <= state_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign state_o   = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one independent button_channel per input
// bit; per-channel repeat-FSM state is exported for observation.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int N_BUTTONS           = 2,
   parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN           = 1,
   parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
   parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
   input  logic                   CLOCK,
   input  logic                   RESET,
   button_if.slave                bus,
   output logic [2*N_BUTTONS-1:0] dbg_state_o
);

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
      rep_state_e ch_state;

      button_channel #(
         .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
         .REPEAT_EN          (REPEAT_EN),
         .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
         .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
      ) u_ch (
         .CLOCK    (CLOCK),
         .RESET    (RESET),
         .button_i (bus.BUTTONS[g]),
         .level_o  (bus.BTN_LEVEL[g]),
         .press_o  (bus.BTN_PRESS[g]),
         .release_o(bus.BTN_RELEASE[g]),
         .state_o  (ch_state)
      );

      assign dbg_state_o[2*g +: 2] = ch_state;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLOCK and RESET (active-low; asynchronous assert).
REQ-002 Parameter N_BUTTONS, default 2: number of independent button channels.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1250000 (10 ms at 125 MHz): consecutive stable samples required to accept a level change; legal range >= 2.
REQ-004 Parameter REPEAT_EN, default 1: 1 enables auto-repeat press pulses while held.
REQ-005 Parameter REPEAT_DELAY_CYCLES, default 62500000 (500 ms): cycles from the initial press pulse to the first repeat pulse; legal range >= 2.
REQ-006 Parameter REPEAT_RATE_CYCLES, default 12500000 (100 ms): cycles between subsequent repeat pulses; legal range >= 2.
REQ-007 Ports:
  - CLOCK  input  1  system clock, 125 MHz
  - RESET  input  1  asynchronous, active-low reset
  - BUTTONS  input  N_BUTTONS  raw, asynchronous, bouncing button levels
  - BTN_LEVEL  output  N_BUTTONS  debounced level
  - BTN_PRESS  output  N_BUTTONS  one-cycle pulse on each accepted press and each repeat
  - BTN_RELEASE  output  N_BUTTONS  one-cycle pulse on each accepted release

Function
REQ-008 Each BUTTONS bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-009 Per channel, a debounce counter SHALL increment on every edge where the synchronized sample differs from BTN_LEVEL, and clear on any edge where they match.
REQ-010 On the DEBOUNCE_CYCLES-th consecutive differing edge, BTN_LEVEL SHALL take the sampled value and the counter SHALL clear. A raw change is therefore visible on BTN_LEVEL after the (DEBOUNCE_CYCLES+2)-th rising edge, counting the first edge that samples it.
REQ-011 Any raw pulse or glitch shorter than DEBOUNCE_CYCLES samples SHALL leave BTN_LEVEL, BTN_PRESS and BTN_RELEASE unchanged.
REQ-012 BTN_PRESS SHALL be high for exactly the first cycle in which BTN_LEVEL is 1. BTN_RELEASE SHALL be high for exactly the first cycle in which BTN_LEVEL is 0 after having been 1.
REQ-013 Each channel SHALL have a repeat FSM with these states:
  - IDLE: leaves to HOLD when BTN_LEVEL rises.
  - HOLD: leaves to REPEAT after REPEAT_DELAY_CYCLES, emitting a BTN_PRESS pulse.
  - REPEAT: emits a BTN_PRESS pulse every REPEAT_RATE_CYCLES.
  - Any state SHALL return to IDLE when BTN_LEVEL falls.
REQ-014 With REPEAT_EN=0, the FSM SHALL remain in IDLE/HOLD and SHALL emit no repeat pulses.
REQ-015 If BTN_LEVEL falls on the same edge a repeat timer expires, the release SHALL win: BTN_RELEASE pulses, no BTN_PRESS pulse is emitted, and the FSM goes to IDLE.
REQ-016 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same cycle.
REQ-017 Counters SHALL be sized $clog2(max cycle parameter + 1) bits and SHALL never wrap.

Reset
REQ-018 While RESET=0, all outputs SHALL be 0, all synchronizer flops and counters 0, and every FSM in IDLE.
REQ-019 Reset asserted mid-debounce or mid-repeat SHALL abort the operation immediately, with no pulse emitted.
REQ-020 A button held through reset deassertion SHALL produce a normal press (BTN_PRESS) once debounced; this is intended behaviour.

Structure
REQ-021 FSM state encodings (IDLE/HOLD/REPEAT) and the default timing constants SHALL live in the shared package/header used by the lab designs.
REQ-022 One sub-module, button_channel, SHALL implement a single channel (synchronizer, debounce, pulse, repeat FSM). The top SHALL instantiate it N_BUTTONS times via generate.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3)
REQ-023 Clean press:
  - Stimulus: BUTTONS[0] 0->1, held.
  - Response: BTN_LEVEL[0]=1 after edge 6; BTN_PRESS[0] high for one cycle after edge 6; BTN_RELEASE stays 0.
REQ-024 Bounce:
  - Stimulus: BUTTONS[1] high 3 cycles, low 1, high 3, then low.
  - Response: BTN_LEVEL[1], BTN_PRESS[1] and BTN_RELEASE[1] stay 0 throughout.
REQ-025 Auto-repeat:
  - Stimulus: BUTTONS[0] held 30 cycles after the press pulse at edge E.
  - Response: BTN_PRESS[0] pulses at E, E+10, E+13, E+16, ..., E+28. After release, BTN_RELEASE[0] pulses once and no further press pulses occur.
REQ-026 Release/repeat collision:
  - Stimulus: release timed so BTN_LEVEL falls on edge E+10.
  - Response: BTN_RELEASE[0]=1 and BTN_PRESS[0]=0 in that cycle.
REQ-027 Simultaneous press:
  - Stimulus: both BUTTONS bits rise on the same cycle.
  - Response: BTN_PRESS=2'b11 for one cycle after edge 6.
REQ-028 Reset mid-repeat:
  - Stimulus: RESET=0 asserted asynchronously between clock edges while in REPEAT.
  - Response: all outputs 0 immediately. After deassertion with the button still held, BTN_PRESS pulses once after edge 6, then repeats resume from HOLD timing.
